// File: rtl/method_call_arbiter_if.sv
// Client-side and method-side signal bundle for method_call_arbiter.
// slave = arbiter view, master = environment (clients + generated method) view.
interface method_call_arbiter_if #(
  parameter int N     = 4,
  parameter int ARG_W = 32,
  parameter int RET_W = 32
);
  logic [N-1:0]       cl_req;
  logic [N*ARG_W-1:0] cl_arg;
  logic [N-1:0]       cl_busy;
  logic [N-1:0]       cl_done;
  logic               cl_timeout;
  logic [RET_W-1:0]   cl_return;
  logic               m_req;
  logic [ARG_W-1:0]   m_args;
  logic               m_busy;
  logic [RET_W-1:0]   m_return;

  modport slave (
    input  cl_req, cl_arg, m_busy, m_return,
    output cl_busy, cl_done, cl_timeout, cl_return, m_req, m_args
  );

  modport master (
    output cl_req, cl_arg, m_busy, m_return,
    input  cl_busy, cl_done, cl_timeout, cl_return, m_req, m_args
  );
endinterface

// File: rtl/method_call_arbiter.sv
// Round-robin sharing of one generated method (req/busy/args/return) among N
// clients, with per-call timeout abort.
module method_call_arbiter #(
  parameter int N       = 4,
  parameter int ARG_W   = 32,
  parameter int RET_W   = 32,
  parameter int TIMEOUT = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  method_call_arbiter_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] COMPLETE  = 3'd4;

  logic [2:0]                 state;
  logic [N-1:0]               pending;
  logic [N-1:0][ARG_W-1:0]    arg_q;
  logic [IW-1:0]              grant, last;
  logic [31:0]                cnt, cnt_nxt;
  logic                       to_hit;
  logic [N-1:0]               busy;
  logic [IW-1:0]              sel;
  logic                       sel_vld;

  assign cnt_nxt = cnt + 32'd1;
  // The count reaches TIMEOUT on the same edge that enters COMPLETE.
  assign to_hit  = (cnt_nxt >= 32'(TIMEOUT));

  // First pending client after last, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last) + k;
      if (idx >= N) idx = idx - N;
      if (!sel_vld && pending[idx]) begin
        sel_vld = 1'b1;
        sel     = IW'(idx);
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign busy[i] = pending[i] | ((state != IDLE) && (grant == IW'(i)));
  end

  // A busy client's request is dropped and its latched argument kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      arg_q   <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.cl_req[i] && !busy[i]) begin
          pending[i] <= 1'b1;
          arg_q[i]   <= bus.cl_arg[i*ARG_W +: ARG_W];
        end else if (state == IDLE && sel_vld && sel == IW'(i)) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      grant          <= '0;
      last           <= IW'(N-1);
      cnt            <= '0;
      bus.m_args     <= '0;
      bus.cl_return  <= '0;
      bus.cl_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (sel_vld) begin
          state      <= ISSUE;
          grant      <= sel;
          last       <= sel;
          bus.m_args <= arg_q[sel];
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          cnt <= cnt_nxt;
          if (to_hit) begin
            state          <= COMPLETE;
            bus.cl_return  <= '0;
            bus.cl_timeout <= 1'b1;
          end else if (bus.m_busy) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          cnt <= cnt_nxt;
          if (!bus.m_busy) begin
            state          <= COMPLETE;
            bus.cl_return  <= bus.m_return;
            bus.cl_timeout <= 1'b0;
          end else if (to_hit) begin
            state          <= COMPLETE;
            bus.cl_return  <= '0;
            bus.cl_timeout <= 1'b1;
          end
        end
        COMPLETE: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign bus.m_req   = (state == ISSUE);
  assign bus.cl_busy = busy;
  assign bus.cl_done = (state == COMPLETE) ? ({{(N-1){1'b0}}, 1'b1} << grant) : '0;
endmodule

// File: tb/tb_method_call_arbiter.sv
// Scoreboard bench for method_call_arbiter: stimulus pushes expected calls and
// completions, a negedge monitor pops and compares them as the DUT presents them.
module tb_method_call_arbiter;
  localparam int N = 4, AW = 32, RW = 32, TO = 50;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  method_call_arbiter_if #(.N(N), .ARG_W(AW), .RET_W(RW)) bus ();

  method_call_arbiter #(.N(N), .ARG_W(AW), .RET_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct { int cl; logic [31:0] ret; logic to; int lat; } done_t;
  done_t       exp_done[$];
  logic [31:0] exp_call[$];
  int tests = 0, fails = 0;
  int cyc = 0, mreq_cyc = 0;
  logic hang = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Method stub: busy for 3 cycles after m_req and returns arg+1; a call issued
  // while hang is set keeps busy high forever.
  logic [3:0] bcnt;
  logic       hang_q;
  always @(posedge clk) begin
    if (reset) begin
      bus.m_busy   <= 1'b0;
      bus.m_return <= '0;
      bcnt         <= '0;
      hang_q       <= 1'b0;
    end else if (bus.m_req) begin
      bus.m_busy   <= 1'b1;
      bus.m_return <= bus.m_args + 32'd1;
      bcnt         <= 4'd3;
      hang_q       <= hang;
    end else if (bcnt != 0 && !hang_q) begin
      bcnt <= bcnt - 4'd1;
      if (bcnt == 4'd1) bus.m_busy <= 1'b0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    done_t e;
    logic [31:0] a;
    cyc++;
    if (bus.m_req === 1'b1) begin
      mreq_cyc = cyc;
      if (exp_call.size() == 0) chk("m_req_unexpected", 32'd1, 32'd0);
      else begin
        a = exp_call.pop_front();
        chk("m_args", bus.m_args, a);
      end
    end
    if (bus.cl_done !== '0) begin
      if (exp_done.size() == 0) chk("cl_done_unexpected", 32'(bus.cl_done), 32'd0);
      else begin
        e = exp_done.pop_front();
        chk("cl_done_client", 32'(bus.cl_done), 32'd1 << e.cl);
        chk("cl_return", bus.cl_return, e.ret);
        chk("cl_timeout", 32'(bus.cl_timeout), 32'(e.to));
        chk("done_latency", 32'(cyc - mreq_cyc), 32'(e.lat));
      end
    end
  end

  task automatic push(input int cl, input logic [31:0] arg, input logic [31:0] ret,
                      input logic to, input int lat);
    done_t e;
    e.cl = cl; e.ret = ret; e.to = to; e.lat = lat;
    exp_call.push_back(arg);
    exp_done.push_back(e);
  endtask

  task automatic pulse(input logic [3:0] mask, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] a2, input logic [31:0] a3);
    @(negedge clk);
    bus.cl_req = mask;
    bus.cl_arg = {a3, a2, a1, a0};
    @(negedge clk);
    bus.cl_req = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_m_req", 32'(bus.m_req), 32'd0);
    chk("rst_m_args", bus.m_args, 32'd0);
    chk("rst_cl_busy", 32'(bus.cl_busy), 32'd0);
    chk("rst_cl_done", 32'(bus.cl_done), 32'd0);
    chk("rst_cl_timeout", 32'(bus.cl_timeout), 32'd0);
    chk("rst_cl_return", bus.cl_return, 32'd0);
    reset = 1'b0;
  endtask

  task automatic wait_done(input int idx);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.cl_done[idx] === 1'b1) return;
    end
    chk("wait_done_bound", 32'd1, 32'd0);
  endtask

  task automatic wait_mreq();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.m_req === 1'b1) return;
    end
    chk("wait_mreq_bound", 32'd1, 32'd0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (exp_done.size() == 0 && exp_call.size() == 0 && bus.cl_busy == '0) begin
        repeat (8) @(negedge clk);
        chk("idle_no_extra_done", 32'(exp_done.size()), 32'd0);
        return;
      end
    end
    chk("wait_idle_bound", 32'(exp_done.size()), 32'd0);
  endtask

  initial begin
    bus.cl_req = '0;
    bus.cl_arg = '0;
    do_reset();

    // Single call with timing of busy and m_req
    push(0, 32'h64, 32'h65, 1'b0, 5);
    pulse(4'b0001, 32'h64, 0, 0, 0);
    chk("t1_busy", 32'(bus.cl_busy[0]), 32'd1);
    chk("t1_no_mreq_yet", 32'(bus.m_req), 32'd0);
    @(negedge clk);
    chk("t1_mreq_t2", 32'(bus.m_req), 32'd1);
    wait_idle();

    // All clients at once: order 0,1,2,3
    do_reset();
    for (int i = 0; i < 4; i++) push(i, 32'(10*(i+1)), 32'(10*(i+1)+1), 1'b0, 5);
    pulse(4'b1111, 32'd10, 32'd20, 32'd30, 32'd40);
    wait_idle();

    // Fairness: 1 and 2 alternate while each re-requests after its done
    push(1, 32'h100, 32'h101, 1'b0, 5);
    push(2, 32'h200, 32'h201, 1'b0, 5);
    pulse(4'b0110, 0, 32'h100, 32'h200, 0);
    wait_done(1);
    push(1, 32'h110, 32'h111, 1'b0, 5);
    pulse(4'b0010, 0, 32'h110, 0, 0);
    wait_done(2);
    push(2, 32'h210, 32'h211, 1'b0, 5);
    pulse(4'b0100, 0, 0, 32'h210, 0);
    wait_idle();

    // Dropped requests: while busy and in the cl_done cycle
    push(0, 32'h10, 32'h11, 1'b0, 5);
    pulse(4'b0001, 32'h10, 0, 0, 0);
    pulse(4'b0001, 32'hFF, 0, 0, 0);
    wait_done(0);
    bus.cl_req = 4'b0001;
    bus.cl_arg = {96'd0, 32'h77};
    @(negedge clk);
    bus.cl_req = '0;
    chk("drop_busy_after_done", 32'(bus.cl_busy), 32'd0);
    wait_idle();

    // Timeout on client 1, client 2 then served normally
    hang = 1'b1;
    push(1, 32'h500, 32'h0, 1'b1, TO + 1);
    push(2, 32'h600, 32'h601, 1'b0, 5);
    pulse(4'b0110, 0, 32'h500, 32'h600, 0);
    wait_mreq();
    @(negedge clk);
    hang = 1'b0;
    wait_idle();

    // Reset during WAIT_DONE with clients 1 and 2 pending
    exp_call.push_back(32'h700);
    pulse(4'b0111, 32'h700, 32'h710, 32'h720, 0);
    wait_mreq();
    repeat (2) @(negedge clk);
    do_reset();
    push(0, 32'h800, 32'h801, 1'b0, 5);
    push(1, 32'h810, 32'h811, 1'b0, 5);
    pulse(4'b0011, 32'h800, 32'h810, 0, 0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/method_call_arbiter.md
# method_call_arbiter

Shares one Synthesijer-generated method interface (`req`/`busy`/args/`return`) among `N` requesting clients. Each client posts a one-cycle call request with arguments. The arbiter grants callers in round-robin order and drives the method handshake. It then returns the result and a completion pulse to the caller, with a timeout guard against a hung method. It sits between client logic and a generated module instance, in place of a directly wired `*_req` or `*_busy` pair.

## Interface
Parameters:
- `N` (default 4): number of clients, 2..8.
- `ARG_W` (default 32): method argument width.
- `RET_W` (default 32): method return width.
- `TIMEOUT` (default 100000): maximum cycles spent waiting on the method before abort.

Ports:
- `clk`  in  1  single clock, all logic on its rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `cl_req`  in  N  per-client one-cycle call request.
- `cl_arg`  in  N*ARG_W  per-client argument; slice i is `[i*ARG_W +: ARG_W]`, sampled with `cl_req[i]`.
- `cl_busy`  out  N  client has a call pending or in service.
- `cl_done`  out  N  one-cycle completion pulse to the served client.
- `cl_timeout`  out  1  valid with `cl_done`; 1 means the call was aborted.
- `cl_return`  out  RET_W  result; valid with `cl_done`, held until the next completion.
- `m_req`  out  1  method request to the generated module.
- `m_args`  out  ARG_W  method argument.
- `m_busy`  in  1  method busy from the generated module.
- `m_return`  in  RET_W  method return value.

## Operation
- **Request capture.**
  - If `cl_req[i]=1` and `cl_busy[i]=0`, set `pending[i]` and latch the argument slice into `arg_q[i]`.
  - If `cl_busy[i]=1`, `cl_req[i]` is ignored and the request is dropped; `arg_q[i]` is not overwritten.
- **Busy indication.** `cl_busy[i] = pending[i] | (state≠IDLE & grant==i)`.
- **Round-robin.**
  - In IDLE with any registered `pending` bit set, select the first set bit searching from `last+1` and wrapping modulo N.
  - Set `grant` and `last` to that client, clear its pending bit, and load `m_args` from its `arg_q`.
  - `last` resets to N-1, so client 0 has first priority.
- **FSM.**
  - IDLE → ISSUE when any pending bit is set.
  - ISSUE: `m_req=1` for exactly this one cycle; go to WAIT_BUSY.
  - WAIT_BUSY: go to WAIT_DONE when `m_busy=1`.
  - WAIT_DONE: go to COMPLETE when `m_busy=0`.
  - COMPLETE: `cl_done[grant]=1`; go to IDLE.
- **Timeout.**
  - A 32-bit counter clears in ISSUE and increments in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT, go to COMPLETE with `cl_timeout=1` and `cl_return=0`.
- **Normal completion.** `cl_return` is loaded from `m_return`, sampled in the last WAIT_DONE cycle (the one where `m_busy=0`), with `cl_timeout=0`.
- **Reset values.**
  - All outputs are 0: `m_req`, `m_args`, `cl_busy`, `cl_done`, `cl_timeout`, `cl_return`.
  - State is IDLE, pending is 0, `last` is N-1, the counter is 0.
- **Reset mid-operation.** The in-flight call is abandoned with no `cl_done`, and pending requests are discarded. The generated module is reset by the same `reset`.

## Timing
- `cl_req[i]` at cycle t, arbiter idle:
  - `pending[i]` and `cl_busy[i]` are high at t+1.
  - IDLE selects at t+1.
  - `m_req` is high at t+2 only.
- Minimum call, where `m_busy` is high for one cycle at t+3 and low at t+4: COMPLETE at t+5, `cl_done` at t+5. Request-to-done minimum is 5 cycles.
- `cl_busy[i]` stays high through the `cl_done` cycle and drops the next cycle. A `cl_req[i]` in the `cl_done` cycle is dropped; the earliest re-request is the cycle after `cl_done`.
- Back-to-back grants: COMPLETE → IDLE → ISSUE gives 2 cycles between one client's `cl_done` and the next `m_req`.
- `m_args` is stable from ISSUE through COMPLETE.
- Simultaneous requests from several clients in one cycle: all are captured; service follows round-robin order.
- `m_busy` rising in the ISSUE cycle is not sampled; it is first observed in WAIT_BUSY.

## Test plan
- **Single call.** After reset, client 0 pulses `cl_req` with arg `0x64`. The stub method returns arg+1 after 3 busy cycles. Required: `m_req` pulses once with `m_args=0x64`; `cl_done[0]` fires; `cl_return=0x65`; `cl_timeout=0`.
- **All clients at once.** Clients 0..3 request in the same cycle with args 10, 20, 30, 40. Required: grant order 0,1,2,3; returns 11, 21, 31, 41; one `cl_done` per client.
- **Fairness.** Client 1 re-requests immediately after each of its `cl_done`, while client 2 holds a request. Required: grant order alternates 1, 2, 1, 2, with no starvation of client 2.
- **Dropped request.**
  - Client 0 pulses `cl_req` again with arg `0xFF` while busy. Required: ignored; the original argument is used; exactly one `cl_done`.
  - A request placed in the `cl_done` cycle is also dropped.
- **Timeout.** With TIMEOUT=50, the stub holds `m_busy=1` forever. Required: `cl_done` with `cl_timeout=1` and `cl_return=0` occurs 51 cycles after `m_req`; the next pending client is then served normally.
- **Reset mid-call.** Assert `reset` during WAIT_DONE with 2 clients pending. Required: all outputs 0 the next cycle; no `cl_done`; pending cleared; a fresh client 0 request is served first.
